// File: rtl/disp_arbiter_if.sv
// Display-arbiter bus: request/word inputs toward the arbiter and registered display outputs back.
interface disp_arbiter_if;
  logic [3:0]  req;
  logic [19:0] hello_in;
  logic [19:0] edit_in;
  logic [19:0] help_in;
  logic [19:0] err_in;
  logic        err_ack;
  logic [19:0] disp;
  logic [3:0]  grant;
  logic        err_active;

  modport master (
    output req, hello_in, edit_in, help_in, err_in, err_ack,
    input  disp, grant, err_active
  );

  modport slave (
    input  req, hello_in, edit_in, help_in, err_in, err_ack,
    output disp, grant, err_active
  );
endinterface

// File: rtl/disp_arbiter.sv
// Display source arbiter: priority grant with minimum hold time and edge-triggered error preemption.
module disp_arbiter #(
  parameter int unsigned HOLD  = 4,
  parameter logic [19:0] BLANK = 20'hFFFFF
) (
  input  logic           clk,
  input  logic           rst,
  disp_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORMAL,
    ST_ERROR
  } state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req3_q;
  logic [19:0] disp_q, disp_d;

  logic        err_set;
  logic [3:0]  winner;

  assign err_set = bus.req[3] & ~req3_q;

  always_comb begin
    winner = '0;
    if (bus.req[2])      winner = 4'b0100;
    else if (bus.req[1]) winner = 4'b0010;
    else if (bus.req[0]) winner = 4'b0001;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;

    if (err_set) begin
      state_d = ST_ERROR;
      grant_d = 4'b1000;
      cnt_d   = HOLD_M1;
    end else begin
      case (state_q)
        ST_ERROR: begin
          // Acks arriving while the hold is still running are dropped, not queued.
          if (bus.err_ack && cnt_q == 8'd0) begin
            grant_d = winner;
            cnt_d   = HOLD_M1;
            state_d = (winner == 4'b0000) ? ST_IDLE : ST_NORMAL;
          end
        end
        default: begin
          if (cnt_q == 8'd0 && winner != 4'b0000 && winner != grant_q) begin
            grant_d = winner;
            cnt_d   = HOLD_M1;
            state_d = ST_NORMAL;
          end
        end
      endcase
    end
  end

  always_comb begin
    disp_d = BLANK;
    case (grant_q)
      4'b0001: disp_d = bus.hello_in;
      4'b0010: disp_d = bus.edit_in;
      4'b0100: disp_d = bus.help_in;
      4'b1000: disp_d = bus.err_in;
      default: disp_d = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      req3_q  <= 1'b0;
      disp_q  <= BLANK;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      req3_q  <= bus.req[3];
      disp_q  <= disp_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.disp       = disp_q;
  assign bus.err_active = (state_q == ST_ERROR);

endmodule
